// File: rtl/lb_ctrl.sv
// Line-buffer ring sequencer: steers the pixel stream into one of four
// line buffers while the other three are swept as 3x3 window rows.
module lb_ctrl #(
    parameter int LINE_W = 8,
    parameter int NUM_LB = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              win_valid,
    output logic [1:0]        top_sel,
    output logic [NUM_LB-1:0] lb_we,
    output logic [NUM_LB-1:0] lb_oe,
    output logic [NUM_LB-1:0] lb_rst_n,
    output logic [2:0]        lines_full
);

    localparam int          CW      = $clog2(LINE_W);
    localparam logic [CW-1:0] WR_LAST = CW'(LINE_W - 1);
    localparam logic [CW-1:0] RD_LAST = CW'(LINE_W - 3);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_READ   = 2'd1,
        ST_REWIND = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        wr_sel_q, wr_sel_d;
    logic [CW-1:0]     wr_col_q, wr_col_d;
    logic [CW-1:0]     rd_col_q, rd_col_d;
    logic [1:0]        top_sel_q, top_sel_d;
    logic [2:0]        lines_full_q, lines_full_d;
    logic [NUM_LB-1:0] lb_rst_n_q, lb_rst_n_d;

    logic              accept;
    logic              line_done;
    logic              handshake;
    logic              sweep_end;
    logic [NUM_LB-1:0] wr_onehot;
    logic [NUM_LB-1:0] rd_mask;

    // Handshakes, strobes and next-state for counters and the sequencing FSM
    always_comb begin
        state_d      = state_q;
        wr_sel_d     = wr_sel_q;
        wr_col_d     = wr_col_q;
        rd_col_d     = rd_col_q;
        top_sel_d    = top_sel_q;
        lines_full_d = lines_full_q;
        lb_rst_n_d   = '1;
        lb_we        = '0;
        lb_oe        = '0;

        wr_onehot = '0;
        wr_onehot[wr_sel_q] = 1'b1;

        // Window rows are the three buffers starting at top_sel, wrapping mod 4
        rd_mask = '0;
        rd_mask[top_sel_q]         = 1'b1;
        rd_mask[top_sel_q + 2'd1]  = 1'b1;
        rd_mask[top_sel_q + 2'd2]  = 1'b1;

        // No writes while all four lines are full or during the rewind cycle
        in_ready  = ~rst & (lines_full_q != 3'd4) & (state_q != ST_REWIND);
        accept    = in_valid & in_ready;
        line_done = accept & (wr_col_q == WR_LAST);

        win_valid = ~rst & (state_q == ST_READ);
        handshake = win_valid & out_ready;
        sweep_end = handshake & (rd_col_q == RD_LAST);

        if (accept) begin
            lb_we    = wr_onehot;
            wr_col_d = line_done ? '0 : wr_col_q + 1'b1;
            if (line_done) begin
                wr_sel_d = wr_sel_q + 2'd1;
            end
        end

        if (handshake) begin
            lb_oe    = rd_mask;
            rd_col_d = sweep_end ? '0 : rd_col_q + 1'b1;
        end

        // Swept buffers get their pointers rewound; contents stay intact
        if (sweep_end) begin
            top_sel_d  = top_sel_q + 2'd1;
            lb_rst_n_d = ~rd_mask;
        end

        // A line completing in the same cycle as a sweep end cancels out
        case ({line_done, sweep_end})
            2'b10:   lines_full_d = lines_full_q + 3'd1;
            2'b01:   lines_full_d = lines_full_q - 3'd1;
            default: lines_full_d = lines_full_q;
        endcase

        case (state_q)
            ST_WAIT:   if (lines_full_q >= 3'd3) state_d = ST_READ;
            ST_READ:   if (sweep_end) state_d = ST_REWIND;
            ST_REWIND: state_d = (lines_full_q >= 3'd3) ? ST_READ : ST_WAIT;
            default:   state_d = ST_WAIT;
        endcase
    end

    // State and counter registers; reset discards any partial line or sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_WAIT;
            wr_sel_q     <= '0;
            wr_col_q     <= '0;
            rd_col_q     <= '0;
            top_sel_q    <= '0;
            lines_full_q <= '0;
            lb_rst_n_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_sel_q     <= wr_sel_d;
            wr_col_q     <= wr_col_d;
            rd_col_q     <= rd_col_d;
            top_sel_q    <= top_sel_d;
            lines_full_q <= lines_full_d;
            lb_rst_n_q   <= lb_rst_n_d;
        end
    end

    assign top_sel    = top_sel_q;
    assign lines_full = lines_full_q;
    assign lb_rst_n   = lb_rst_n_q;

endmodule

// File: tb/tb_lb_ctrl.sv
// Bench for lb_ctrl: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a pixel/window counting model.
module tb_lb_ctrl;

    localparam int LW = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       win_valid;
    logic [1:0] top_sel;
    logic [3:0] lb_we;
    logic [3:0] lb_oe;
    logic [3:0] lb_rst_n;
    logic [2:0] lines_full;

    int tests = 0;
    int fails = 0;

    lb_ctrl #(.LINE_W(LW), .NUM_LB(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_ready(out_ready), .win_valid(win_valid),
        .top_sel(top_sel), .lb_we(lb_we), .lb_oe(lb_oe),
        .lb_rst_n(lb_rst_n), .lines_full(lines_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks pixels in the current line, which buffer is written, how many
    // lines wait to be swept, how many windows of the sweep are consumed and
    // whether the consumer side is idle(0), reading(1) or rewinding(2).
    int m_pix = 0, m_wbuf = 0, m_full = 0, m_top = 0, m_win = 0, m_mode = 0;
    int m_rstn = 0;

    function automatic int rows(input int t);
        return (1 << t) | (1 << ((t + 1) % 4)) | (1 << ((t + 2) % 4));
    endfunction

    always @(negedge clk) begin
        int ir, we, wv, oe, hs, ldone, send, old_full;
        ir = (!rst && m_full != 4 && m_mode != 2) ? 1 : 0;
        we = (in_valid && ir) ? (1 << m_wbuf) : 0;
        wv = (!rst && m_mode == 1) ? 1 : 0;
        hs = (wv && out_ready) ? 1 : 0;
        oe = hs ? rows(m_top) : 0;
        chk("m_in_ready", 8'(in_ready), 8'(ir));
        chk("m_win_valid", 8'(win_valid), 8'(wv));
        chk("m_lb_we", 8'(lb_we), 8'(we));
        chk("m_lb_oe", 8'(lb_oe), 8'(oe));
        chk("m_lb_rst_n", 8'(lb_rst_n), 8'(m_rstn));
        chk("m_lines_full", 8'(lines_full), 8'(m_full));
        chk("m_top_sel", 8'(top_sel), 8'(m_top));
        chk("m_full_range", 8'(lines_full <= 3'd4), 8'd1);
        if (rst) begin
            m_pix = 0; m_wbuf = 0; m_full = 0; m_top = 0; m_win = 0;
            m_mode = 0; m_rstn = 0;
        end else begin
            old_full = m_full;
            ldone = (we != 0 && m_pix == LW - 1) ? 1 : 0;
            send  = (hs && m_win == LW - 3) ? 1 : 0;
            if (we != 0) m_pix = (m_pix + 1) % LW;
            if (ldone) m_wbuf = (m_wbuf + 1) % 4;
            if (hs) m_win = (m_win + 1) % (LW - 2);
            m_rstn = send ? (15 & ~rows(m_top)) : 15;
            m_full = m_full + ldone - send;
            if (send) m_top = (m_top + 1) % 4;
            if (m_mode == 1) m_mode = send ? 2 : 1;
            else m_mode = (old_full >= 3) ? 1 : 0;
        end
    end

    // Advance one clock, then apply new inputs; outputs settle by #2
    task automatic cyc(input logic r, input logic iv, input logic ordy);
        @(posedge clk);
        #1;
        rst = r; in_valid = iv; out_ready = ordy;
        #1;
    endtask

    task automatic do_reset();
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
    endtask

    task automatic fill24();
        for (int i = 0; i < 24; i++) begin
            cyc(0, 1, 0);
            chk("fill_we", 8'(lb_we), 8'(1 << (i / 8)));
        end
    endtask

    initial begin
        // Reset held with in_valid high
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0);
            chk("rst_in_ready", 8'(in_ready), 8'd0);
            chk("rst_we", 8'(lb_we), 8'd0);
            chk("rst_win_valid", 8'(win_valid), 8'd0);
            chk("rst_lb_rst_n", 8'(lb_rst_n), 8'h0);
        end
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("rel_lb_rst_n", 8'(lb_rst_n), 8'hf);

        // Fill three lines
        fill24();
        cyc(0, 0, 0);
        chk("fill_lines_full", 8'(lines_full), 8'd3);
        chk("fill_wv_early", 8'(win_valid), 8'd0);
        cyc(0, 0, 0);
        chk("fill_wv", 8'(win_valid), 8'd1);
        chk("fill_top", 8'(top_sel), 8'd0);

        // Full sweep
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 1);
            chk("sweep_oe", 8'(lb_oe), 8'h7);
        end
        cyc(0, 0, 0);
        chk("rewind_rst_n", 8'(lb_rst_n), 8'h8);
        chk("rewind_wv", 8'(win_valid), 8'd0);
        chk("rewind_in_ready", 8'(in_ready), 8'd0);
        chk("rewind_top", 8'(top_sel), 8'd1);
        chk("rewind_full", 8'(lines_full), 8'd2);
        cyc(0, 0, 0);
        chk("wait_wv", 8'(win_valid), 8'd0);
        chk("wait_in_ready", 8'(in_ready), 8'd1);

        // Backpressure: two more lines fill the ring
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 0);
            chk("bp_we", 8'(lb_we), 8'(i < 8 ? 8 : 1));
        end
        cyc(0, 1, 0);
        chk("bp_in_ready", 8'(in_ready), 8'd0);
        chk("bp_we_blocked", 8'(lb_we), 8'd0);
        chk("bp_full", 8'(lines_full), 8'd4);

        // Concurrent line completion and sweep end
        do_reset();
        fill24();
        cyc(0, 0, 0);
        for (int j = 0; j < 8; j++) begin
            cyc(0, 1, j >= 2);
        end
        chk("conc_we", 8'(lb_we), 8'h8);
        chk("conc_oe", 8'(lb_oe), 8'h7);
        cyc(0, 0, 0);
        chk("conc_full", 8'(lines_full), 8'd3);
        chk("conc_rewind_rst_n", 8'(lb_rst_n), 8'h8);
        chk("conc_rewind_wv", 8'(win_valid), 8'd0);
        cyc(0, 0, 0);
        chk("conc_resume_wv", 8'(win_valid), 8'd1);
        chk("conc_top", 8'(top_sel), 8'd1);

        // Stalled sweep then reset at rd_col = 3
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1);
            chk("stall_oe_hs", 8'(lb_oe), 8'he);
            cyc(0, 0, 0);
            chk("stall_oe_idle", 8'(lb_oe), 8'h0);
        end
        cyc(1, 1, 1);
        chk("mid_rst_oe", 8'(lb_oe), 8'h0);
        chk("mid_rst_we", 8'(lb_we), 8'h0);
        chk("mid_rst_wv", 8'(win_valid), 8'd0);
        cyc(1, 0, 0);
        chk("mid_rst_rst_n", 8'(lb_rst_n), 8'h0);
        chk("mid_rst_full", 8'(lines_full), 8'd0);
        chk("mid_rst_top", 8'(top_sel), 8'd0);
        cyc(0, 0, 0);

        // Randomized traffic, checked by the model every cycle
        for (int n = 0; n < 4000; n++) begin
            cyc(($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0);
        end
        cyc(0, 0, 0);

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
